// File: rtl/ofs_asp_pkg.sv
// ---------------------------------------------------------------------------
// ofs_asp_pkg
// Shared ASP local-memory constants and arbiter types.
//   - ASP_LOCALMEM_* : default widths of the local-memory Avalon-MM bank port
//   - ARB_TAG_DEPTH_DEFAULT : default outstanding read-burst capacity
//   - arb_state_e : arbiter command-side state
//   - ch_id_width() : bits needed for a channel id (never less than 1)
// ---------------------------------------------------------------------------
package ofs_asp_pkg;

    localparam int ASP_LOCALMEM_AVMM_ADDR_WIDTH       = 33;
    localparam int ASP_LOCALMEM_AVMM_DATA_WIDTH       = 512;
    localparam int ASP_LOCALMEM_QSYS_BURSTCNT_WIDTH   = 7;
    localparam int ASP_LOCALMEM_AVMM_BYTEENABLE_WIDTH = 64;

    localparam int ARB_TAG_DEPTH_DEFAULT = 64;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WR_BURST = 1'b1
    } arb_state_e;

    // A single channel still needs a 1-bit id so every vector stays legal.
    function automatic int ch_id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/kernel_mem_arb_mux_tag_fifo.sv
// ---------------------------------------------------------------------------
// kernel_mem_arb_tag_fifo
// Synchronous FIFO of read tags {channel id, burstcount}, one entry per
// accepted read burst, popped when the last beat of the head burst returns.
//   clk, reset     : sole clock, asynchronous active-high reset
//   push/push_data : enqueue a tag (ignored while full)
//   pop            : dequeue head (ignored while empty)
//   head_data      : tag at the head
//   full, empty    : occupancy flags
// ---------------------------------------------------------------------------
module kernel_mem_arb_tag_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;

    // Extra pointer MSB distinguishes full from empty when indices match.
    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        head_data = mem_q[rd_ptr_q[PTR_W-1:0]];
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push && !full) begin
            wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/kernel_mem_arb_mux.sv
// ---------------------------------------------------------------------------
// kernel_mem_arb_mux
// Round-robin N-to-1 Avalon-MM arbiter from NUM_CH kernel global-memory
// masters onto one local-memory bank port. Write bursts lock the grant until
// their last beat; read responses are routed back via a tag FIFO; a write
// ack is generated locally one cycle after each write burst completes.
//   clk, reset        : sole clock, asynchronous active-high reset
//   k_* (per channel) : kernel command inputs, waitrequest/readdata/
//                       readdatavalid/writeack outputs
//   m_*               : bank-side command outputs and response inputs
// ---------------------------------------------------------------------------
module kernel_mem_arb_mux
    import ofs_asp_pkg::*;
#(
    parameter int NUM_CH           = 2,
    parameter int ADDR_WIDTH       = ASP_LOCALMEM_AVMM_ADDR_WIDTH,
    parameter int DATA_WIDTH       = ASP_LOCALMEM_AVMM_DATA_WIDTH,
    parameter int BURSTCOUNT_WIDTH = ASP_LOCALMEM_QSYS_BURSTCNT_WIDTH,
    parameter int BYTEENABLE_WIDTH = ASP_LOCALMEM_AVMM_BYTEENABLE_WIDTH,
    parameter int TAG_DEPTH        = ARB_TAG_DEPTH_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    k_read,
    input  logic [NUM_CH-1:0]                    k_write,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]         k_address,
    input  logic [NUM_CH*BURSTCOUNT_WIDTH-1:0]   k_burstcount,
    input  logic [NUM_CH*DATA_WIDTH-1:0]         k_writedata,
    input  logic [NUM_CH*BYTEENABLE_WIDTH-1:0]   k_byteenable,
    output logic [NUM_CH-1:0]                    k_waitrequest,
    output logic [NUM_CH*DATA_WIDTH-1:0]         k_readdata,
    output logic [NUM_CH-1:0]                    k_readdatavalid,
    output logic [NUM_CH-1:0]                    k_writeack,
    output logic                                 m_read,
    output logic                                 m_write,
    output logic [ADDR_WIDTH-1:0]                m_address,
    output logic [BURSTCOUNT_WIDTH-1:0]          m_burstcount,
    output logic [DATA_WIDTH-1:0]                m_writedata,
    output logic [BYTEENABLE_WIDTH-1:0]          m_byteenable,
    input  logic                                 m_waitrequest,
    input  logic [DATA_WIDTH-1:0]                m_readdata,
    input  logic                                 m_readdatavalid
);

    localparam int CH_W  = ch_id_width(NUM_CH);
    localparam int TAG_W = CH_W + BURSTCOUNT_WIDTH;

    arb_state_e                  state_q, state_d;
    logic [CH_W-1:0]             rr_q, rr_d;
    logic [CH_W-1:0]             lock_ch_q, lock_ch_d;
    logic [BURSTCOUNT_WIDTH-1:0] beats_left_q, beats_left_d;
    logic [BURSTCOUNT_WIDTH-1:0] rd_beats_q, rd_beats_d;
    logic [NUM_CH-1:0]           writeack_q, writeack_d;
    logic [NUM_CH-1:0]           rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;

    logic                        grant_vld;
    logic [CH_W-1:0]             grant_ch;
    logic [BURSTCOUNT_WIDTH-1:0] grant_bc_raw;
    logic                        cmd_accept;

    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [TAG_W-1:0]            fifo_push_data, fifo_head;
    logic [CH_W-1:0]             head_ch;
    logic [BURSTCOUNT_WIDTH-1:0] head_bc;

    function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
        if (int'(ch) >= NUM_CH - 1) begin
            return '0;
        end
        return ch + CH_W'(1);
    endfunction

    // Grant selection. Scanning offsets from high to low lets the lowest
    // offset from the rr pointer win without a break.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant_ch  = rr_q;
        if (state_q == WR_BURST) begin
            grant_vld = k_write[lock_ch_q];
            grant_ch  = lock_ch_q;
        end else begin
            for (int off = NUM_CH - 1; off >= 0; off--) begin
                idx = (int'(rr_q) + off) % NUM_CH;
                if (k_write[idx] || (k_read[idx] && !fifo_full)) begin
                    grant_vld = 1'b1;
                    grant_ch  = CH_W'(idx);
                end
            end
        end
    end

    // Zero-latency command mux. Everything is held at its reset value while
    // reset is asserted so the bank sees no command from a stale grant.
    always_comb begin
        m_read        = 1'b0;
        m_write       = 1'b0;
        m_address     = '0;
        m_burstcount  = '0;
        m_writedata   = '0;
        m_byteenable  = '0;
        k_waitrequest = '1;
        grant_bc_raw  = k_burstcount[int'(grant_ch)*BURSTCOUNT_WIDTH +: BURSTCOUNT_WIDTH];
        if (grant_vld && !reset) begin
            m_write      = k_write[grant_ch];
            // A write on the same channel wins over a simultaneous read.
            m_read       = (state_q == IDLE) && k_read[grant_ch] &&
                           !k_write[grant_ch] && !fifo_full;
            m_address    = k_address[int'(grant_ch)*ADDR_WIDTH +: ADDR_WIDTH];
            m_burstcount = (grant_bc_raw == '0) ? BURSTCOUNT_WIDTH'(1) : grant_bc_raw;
            m_writedata  = k_writedata[int'(grant_ch)*DATA_WIDTH +: DATA_WIDTH];
            m_byteenable = k_byteenable[int'(grant_ch)*BYTEENABLE_WIDTH +: BYTEENABLE_WIDTH];
            k_waitrequest[grant_ch] = m_waitrequest;
        end
    end

    assign head_ch = fifo_head[TAG_W-1 -: CH_W];
    assign head_bc = fifo_head[BURSTCOUNT_WIDTH-1:0];

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        lock_ch_d      = lock_ch_q;
        beats_left_d   = beats_left_q;
        rd_beats_d     = rd_beats_q;
        writeack_d     = '0;
        rvalid_d       = '0;
        rdata_d        = rdata_q;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_push_data = {grant_ch, m_burstcount};
        cmd_accept     = (m_read || m_write) && !m_waitrequest;

        if (cmd_accept) begin
            if (state_q == WR_BURST) begin
                beats_left_d = beats_left_q - BURSTCOUNT_WIDTH'(1);
                if (beats_left_q == BURSTCOUNT_WIDTH'(1)) begin
                    state_d               = IDLE;
                    writeack_d[lock_ch_q] = 1'b1;
                    rr_d                  = next_ch(lock_ch_q);
                end
            end else if (m_write) begin
                if (m_burstcount == BURSTCOUNT_WIDTH'(1)) begin
                    writeack_d[grant_ch] = 1'b1;
                    rr_d                 = next_ch(grant_ch);
                end else begin
                    state_d      = WR_BURST;
                    lock_ch_d    = grant_ch;
                    beats_left_d = m_burstcount - BURSTCOUNT_WIDTH'(1);
                end
            end else begin
                fifo_push = 1'b1;
                rr_d      = next_ch(grant_ch);
            end
        end

        // Responses return in issue order; a beat with no tag is dropped.
        if (m_readdatavalid && !fifo_empty) begin
            rvalid_d[head_ch] = 1'b1;
            rdata_d           = m_readdata;
            if (rd_beats_q + BURSTCOUNT_WIDTH'(1) == head_bc) begin
                fifo_pop   = 1'b1;
                rd_beats_d = '0;
            end else begin
                rd_beats_d = rd_beats_q + BURSTCOUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            lock_ch_q    <= '0;
            beats_left_q <= '0;
            rd_beats_q   <= '0;
            writeack_q   <= '0;
            rvalid_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            lock_ch_q    <= lock_ch_d;
            beats_left_q <= beats_left_d;
            rd_beats_q   <= rd_beats_d;
            writeack_q   <= writeack_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
        end
    end

    // Read data is shared; only the addressed channel's valid is raised.
    assign k_readdata      = {NUM_CH{rdata_q}};
    assign k_readdatavalid = rvalid_q;
    assign k_writeack      = writeack_q;

    kernel_mem_arb_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    a_no_read_and_write: assert property (@(posedge clk) disable iff (reset)
        (k_read & k_write) == '0);
    a_burstcount_nonzero: assert property (@(posedge clk) disable iff (reset)
        (grant_vld && state_q == IDLE) |-> (grant_bc_raw != '0));
    a_rvalid_has_tag: assert property (@(posedge clk) disable iff (reset)
        m_readdatavalid |-> !fifo_empty);

endmodule

// File: tb/tb_kernel_mem_arb_mux.sv
// ---------------------------------------------------------------------------
// tb_kernel_mem_arb_mux
// Randomized bench: NUM_CH kernel masters and a bank model with random
// waitrequest and response timing, checked against a transaction-level
// reference (grant order, per-channel read data queues, write acks).
// ---------------------------------------------------------------------------
module tb_kernel_mem_arb_mux;

    localparam int NUM_CH = 4;
    localparam int AW     = 16;
    localparam int DW     = 16;
    localparam int BCW    = 4;
    localparam int BEW    = 2;
    localparam int TAG_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_CH-1:0]       k_read, k_write;
    logic [NUM_CH*AW-1:0]    k_address;
    logic [NUM_CH*BCW-1:0]   k_burstcount;
    logic [NUM_CH*DW-1:0]    k_writedata;
    logic [NUM_CH*BEW-1:0]   k_byteenable;
    logic [NUM_CH-1:0]       k_waitrequest;
    logic [NUM_CH*DW-1:0]    k_readdata;
    logic [NUM_CH-1:0]       k_readdatavalid;
    logic [NUM_CH-1:0]       k_writeack;
    logic                    m_read, m_write;
    logic [AW-1:0]           m_address;
    logic [BCW-1:0]          m_burstcount;
    logic [DW-1:0]           m_writedata;
    logic [BEW-1:0]          m_byteenable;
    logic                    m_waitrequest;
    logic [DW-1:0]           m_readdata;
    logic                    m_readdatavalid;

    always #5 clk = ~clk;

    kernel_mem_arb_mux #(
        .NUM_CH           (NUM_CH),
        .ADDR_WIDTH       (AW),
        .DATA_WIDTH       (DW),
        .BURSTCOUNT_WIDTH (BCW),
        .BYTEENABLE_WIDTH (BEW),
        .TAG_DEPTH        (TAG_DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .k_read          (k_read),
        .k_write         (k_write),
        .k_address       (k_address),
        .k_burstcount    (k_burstcount),
        .k_writedata     (k_writedata),
        .k_byteenable    (k_byteenable),
        .k_waitrequest   (k_waitrequest),
        .k_readdata      (k_readdata),
        .k_readdatavalid (k_readdatavalid),
        .k_writeack      (k_writeack),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_address       (m_address),
        .m_burstcount    (m_burstcount),
        .m_writedata     (m_writedata),
        .m_byteenable    (m_byteenable),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Kernel master bookkeeping
    logic            mst_busy  [NUM_CH];
    logic            mst_wr    [NUM_CH];
    logic [AW-1:0]   mst_addr  [NUM_CH];
    logic [BCW-1:0]  mst_bc    [NUM_CH];
    logic [DW-1:0]   mst_wdata [NUM_CH];
    logic [BEW-1:0]  mst_be    [NUM_CH];
    int              mst_left  [NUM_CH];
    int              acc_cnt   [NUM_CH];

    // Reference model
    int              rr_ptr;
    int              lock_ch;
    int              tags_ch[$];
    int              tags_bc[$];
    int              tag_rcvd;
    logic [DW-1:0]   exp_data[NUM_CH][$];
    logic [NUM_CH-1:0] exp_rvalid, exp_ack;

    // Bank model
    logic [AW-1:0]   sl_addr[$];
    int              sl_bc[$];
    int              sl_beat;

    // Stimulus knobs (percentages)
    int p_start, p_wr, p_wait, p_resp, max_bc;

    function automatic logic [DW-1:0] rd_word(input logic [AW-1:0] a, input int b);
        return DW'(a) ^ DW'(b * 32'h1357) ^ DW'(16'h5A5A);
    endfunction

    function automatic int model_winner();
        int c;
        if (lock_ch >= 0) return k_write[lock_ch] ? lock_ch : -1;
        for (int off = 0; off < NUM_CH; off++) begin
            c = (rr_ptr + off) % NUM_CH;
            if (k_write[c] || (k_read[c] && tags_ch.size() < TAG_DEPTH)) return c;
        end
        return -1;
    endfunction

    task automatic clear_all();
        rr_ptr = 0; lock_ch = -1; tag_rcvd = 0; sl_beat = 0;
        tags_ch.delete(); tags_bc.delete(); sl_addr.delete(); sl_bc.delete();
        exp_rvalid = '0; exp_ack = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_data[c].delete();
            mst_busy[c] = 1'b0; mst_wr[c] = 1'b0; mst_left[c] = 0;
        end
        k_read = '0; k_write = '0; k_address = '0; k_burstcount = '0;
        k_writedata = '0; k_byteenable = '0;
        m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_waitreq"}, 32'(k_waitrequest), 32'({NUM_CH{1'b1}}));
        check_val({tag, "_mcmd"},    32'({m_read, m_write}), 32'd0);
        check_val({tag, "_maddr"},   32'(m_address), 32'd0);
        check_val({tag, "_rvalid"},  32'(k_readdatavalid), 32'd0);
        check_val({tag, "_wack"},    32'(k_writeack), 32'd0);
        check_val({tag, "_rdata"},   32'(k_readdata[DW-1:0]), 32'd0);
    endtask

    task automatic do_cycle();
        int n_acc, acc_ch, exp_ch, c;
        logic [NUM_CH-1:0] rv_nx, ack_nx;
        @(posedge clk); #1;
        // Registered outputs from the previous cycle
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check_val("rvalid", 32'(k_readdatavalid[ch]), 32'(exp_rvalid[ch]));
            check_val("writeack", 32'(k_writeack[ch]), 32'(exp_ack[ch]));
            if (k_readdatavalid[ch] && exp_data[ch].size() > 0)
                check_val("rdata", 32'(k_readdata[ch*DW +: DW]), 32'(exp_data[ch].pop_front()));
        end
        // Drive this cycle's inputs
        for (int ch = 0; ch < NUM_CH; ch++) begin
            if (!mst_busy[ch] && $urandom_range(99) < p_start) begin
                mst_busy[ch]  = 1'b1;
                mst_wr[ch]    = ($urandom_range(99) < p_wr);
                mst_addr[ch]  = AW'($urandom);
                mst_bc[ch]    = BCW'($urandom_range(max_bc, 1));
                mst_left[ch]  = int'(mst_bc[ch]);
                mst_wdata[ch] = DW'($urandom);
                mst_be[ch]    = BEW'($urandom);
            end
            k_read[ch]  = mst_busy[ch] && !mst_wr[ch];
            k_write[ch] = mst_busy[ch] && mst_wr[ch];
            k_address[ch*AW +: AW]     = mst_addr[ch];
            k_burstcount[ch*BCW +: BCW] = mst_bc[ch];
            k_writedata[ch*DW +: DW]   = mst_wdata[ch];
            k_byteenable[ch*BEW +: BEW] = mst_be[ch];
        end
        m_waitrequest = ($urandom_range(99) < p_wait);
        if (sl_addr.size() > 0 && $urandom_range(99) < p_resp) begin
            m_readdatavalid = 1'b1;
            m_readdata      = rd_word(sl_addr[0], sl_beat);
        end else begin
            m_readdatavalid = 1'b0;
            m_readdata      = DW'($urandom);
        end
        #1;
        // Command-side comparison against the reference grant
        n_acc = 0; acc_ch = -1;
        for (int ch = 0; ch < NUM_CH; ch++)
            if ((k_read[ch] || k_write[ch]) && !k_waitrequest[ch]) begin
                n_acc++; acc_ch = ch;
            end
        exp_ch = m_waitrequest ? -1 : model_winner();
        check_val("grant", (n_acc > 1) ? 32'hFFFF_FFFE : 32'(acc_ch), 32'(exp_ch));
        rv_nx = '0; ack_nx = '0;
        if (n_acc == 1) begin
            c = acc_ch;
            acc_cnt[c]++;
            check_val("m_addr", 32'(m_address), 32'(mst_addr[c]));
            check_val("m_bc", 32'(m_burstcount), 32'(mst_bc[c]));
            check_val("m_be", 32'(m_byteenable), 32'(mst_be[c]));
            if (mst_wr[c]) begin
                check_val("m_cmd_wr", 32'({m_read, m_write}), 32'd1);
                check_val("m_wdata", 32'(m_writedata), 32'(mst_wdata[c]));
                mst_left[c]--;
                if (mst_left[c] == 0) begin
                    mst_busy[c] = 1'b0; ack_nx[c] = 1'b1;
                    rr_ptr = (c + 1) % NUM_CH; lock_ch = -1;
                end else begin
                    lock_ch = c; mst_wdata[c] = DW'($urandom);
                end
            end else begin
                check_val("m_cmd_rd", 32'({m_read, m_write}), 32'd2);
                for (int b = 0; b < int'(mst_bc[c]); b++)
                    exp_data[c].push_back(rd_word(mst_addr[c], b));
                tags_ch.push_back(c); tags_bc.push_back(int'(mst_bc[c]));
                sl_addr.push_back(m_address); sl_bc.push_back(int'(m_burstcount));
                mst_busy[c] = 1'b0; rr_ptr = (c + 1) % NUM_CH;
            end
        end
        if (m_readdatavalid) begin
            rv_nx[tags_ch[0]] = 1'b1;
            tag_rcvd++;
            if (tag_rcvd == tags_bc[0]) begin
                void'(tags_ch.pop_front()); void'(tags_bc.pop_front()); tag_rcvd = 0;
            end
            sl_beat++;
            if (sl_beat == sl_bc[0]) begin
                void'(sl_addr.pop_front()); void'(sl_bc.pop_front()); sl_beat = 0;
            end
        end
        exp_rvalid = rv_nx;
        exp_ack    = ack_nx;
    endtask

    task automatic run_phase(input int cycles, input int ps, input int pw, input int pwait,
                             input int presp, input int mbc);
        p_start = ps; p_wr = pw; p_wait = pwait; p_resp = presp; max_bc = mbc;
        repeat (cycles) do_cycle();
    endtask

    initial begin
        reset = 1'b1;
        clear_all();
        for (int c = 0; c < NUM_CH; c++) acc_cnt[c] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("init");
        reset = 1'b0;

        // Reads only, bank silent: tag FIFO fills and further reads stall
        run_phase(20, 100, 0, 0, 0, 2);
        // Mixed traffic with random backpressure and response gaps
        run_phase(1500, 40, 50, 30, 50, 8);
        // Heavy backpressure during write bursts
        run_phase(400, 50, 80, 80, 60, 8);
        // All channels streaming single-beat reads: no starvation
        run_phase(20, 0, 0, 0, 100, 1);
        for (int c = 0; c < NUM_CH; c++) acc_cnt[c] = 0;
        run_phase(100, 100, 0, 0, 100, 1);
        for (int c = 0; c < NUM_CH; c++)
            check_val("no_starve", 32'(acc_cnt[c] >= 20), 32'd1);

        // Build up outstanding reads and partial bursts, then reset mid-flight
        run_phase(60, 60, 50, 20, 10, 6);
        #1 reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        clear_all();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("inrst");
        reset = 1'b0;

        // Normal operation after reset, then drain
        run_phase(300, 40, 40, 20, 60, 4);
        run_phase(80, 0, 0, 0, 100, 1);
        check_val("drain_tags", 32'(tags_ch.size()), 32'd0);
        for (int c = 0; c < NUM_CH; c++) begin
            check_val("drain_rd", 32'(exp_data[c].size()), 32'd0);
            check_val("drain_mst", 32'(mst_busy[c]), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
